// File: rtl/reg_wb_stage_pkg.sv
// Shared core definitions: UREG ids, write-back queue depth,
// load tracker state encodings and small id helpers.
package CoreDefs;

    localparam int UREG_W = 7;
    localparam int DATA_W = 32;
    localparam int WB_QDEPTH = 2;

    localparam logic [UREG_W-1:0] UREG_R0 = 7'h00;
    localparam logic [UREG_W-1:0] UREG_R15 = 7'h0F;
    localparam logic [UREG_W-1:0] UREG_SR = 7'h40;
    localparam logic [UREG_W-1:0] UREG_GBR = 7'h41;
    localparam logic [UREG_W-1:0] UREG_VBR = 7'h42;
    localparam logic [UREG_W-1:0] UREG_PR = 7'h43;
    localparam logic [UREG_W-1:0] UREG_MACH = 7'h44;
    localparam logic [UREG_W-1:0] UREG_MACL = 7'h45;
    localparam logic [UREG_W-1:0] UREG_ZZR = 7'h7F;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_PEND = 2'd1,
        LD_STALE = 2'd2
    } ldState_t;

    // UREG_ZZR means "no register" and never matches anything
    function automatic logic idMatch(
        input logic [UREG_W-1:0] a,
        input logic [UREG_W-1:0] b
    );
        idMatch = (a == b) && (a != UREG_ZZR);
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order queue for ALU results waiting for the write port.
// Entry 0 is the head; both entries are exposed for forwarding.
import CoreDefs::*;

module wb_fifo2 (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [UREG_W-1:0] pushId,
    input  logic [DATA_W-1:0] pushVal,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [UREG_W-1:0] entry0Id,
    output logic [DATA_W-1:0] entry0Val,
    output logic [UREG_W-1:0] entry1Id,
    output logic [DATA_W-1:0] entry1Val
);

    logic doPush;
    logic doPop;

    assign doPop = pop && (count != 2'd0);
    assign doPush = push && ((count != 2'd2) || doPop);

    // Shift on pop, fill the first free slot on push
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            entry0Id <= UREG_ZZR;
            entry0Val <= '0;
            entry1Id <= UREG_ZZR;
            entry1Val <= '0;
        end else begin
            if (doPop && doPush) begin
                if (count == 2'd1) begin
                    entry0Id <= pushId;
                    entry0Val <= pushVal;
                end else begin
                    entry0Id <= entry1Id;
                    entry0Val <= entry1Val;
                    entry1Id <= pushId;
                    entry1Val <= pushVal;
                end
            end else if (doPop) begin
                entry0Id <= entry1Id;
                entry0Val <= entry1Val;
                entry1Id <= UREG_ZZR;
                entry1Val <= '0;
                count <= count - 2'd1;
            end else if (doPush) begin
                if (count == 2'd0) begin
                    entry0Id <= pushId;
                    entry0Val <= pushVal;
                end else begin
                    entry1Id <= pushId;
                    entry1Val <= pushVal;
                end
                count <= count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_stage.sv
// Register write-back stage: arbitrates load returns and ALU results
// onto one registered GPR write port, tracks one load, forwards values.
import CoreDefs::*;

module reg_wb_stage (
    input  logic              clock,
    input  logic              reset,
    input  logic              exValid,
    input  logic [UREG_W-1:0] exRegId,
    input  logic [DATA_W-1:0] exRegVal,
    input  logic              exLdStart,
    input  logic [UREG_W-1:0] exLdRegId,
    input  logic              memLdValid,
    input  logic [DATA_W-1:0] memLdData,
    input  logic [UREG_W-1:0] idRegIdRs,
    input  logic [UREG_W-1:0] idRegIdRt,
    output logic              fwdHitRs,
    output logic [DATA_W-1:0] fwdValRs,
    output logic              fwdHitRt,
    output logic [DATA_W-1:0] fwdValRt,
    output logic [UREG_W-1:0] regIdRo,
    output logic [DATA_W-1:0] regValRo,
    output logic              wbHold,
    output logic              wbLdPend,
    output logic              wbOvf
);

    ldState_t          ldState;
    logic [UREG_W-1:0] ldRegId;
    logic              exReal;
    logic              ldWrite;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              dropEx;
    logic [1:0]        fifoCount;
    logic [UREG_W-1:0] headId;
    logic [DATA_W-1:0] headVal;
    logic [UREG_W-1:0] secId;
    logic [DATA_W-1:0] secVal;
    logic [UREG_W-1:0] selId;
    logic [DATA_W-1:0] selVal;

    assign exReal = exValid && (exRegId != UREG_ZZR);
    assign ldWrite = memLdValid && (ldState == LD_PEND)
                     && (ldRegId != UREG_ZZR);
    assign fifoEmpty = (fifoCount == 2'd0);
    assign fifoFull = (fifoCount == 2'(WB_QDEPTH));

    wb_fifo2 uFifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifoPush),
        .pushId    (exRegId),
        .pushVal   (exRegVal),
        .pop       (fifoPop),
        .count     (fifoCount),
        .entry0Id  (headId),
        .entry0Val (headVal),
        .entry1Id  (secId),
        .entry1Val (secVal)
    );

    // Write-port source: load return, then queue head, then fresh result
    always_comb begin
        selId = UREG_ZZR;
        selVal = '0;
        fifoPop = 1'b0;
        fifoPush = 1'b0;
        dropEx = 1'b0;
        if (ldWrite) begin
            selId = ldRegId;
            selVal = memLdData;
        end else if (!fifoEmpty) begin
            selId = headId;
            selVal = headVal;
            fifoPop = 1'b1;
        end else if (exReal) begin
            selId = exRegId;
            selVal = exRegVal;
        end
        if (exReal && (ldWrite || !fifoEmpty)) begin
            fifoPush = !fifoFull;
            dropEx = fifoFull;
        end
    end

    // Registered write port and sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regIdRo <= UREG_ZZR;
            regValRo <= '0;
            wbOvf <= 1'b0;
        end else begin
            regIdRo <= selId;
            regValRo <= selVal;
            if (dropEx) begin
                wbOvf <= 1'b1;
            end
        end
    end

    // Load tracker; STALE means a newer ALU write superseded the load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ldState <= LD_IDLE;
            ldRegId <= UREG_ZZR;
        end else begin
            case (ldState)
                LD_IDLE: begin
                    if (exLdStart) begin
                        ldState <= LD_PEND;
                        ldRegId <= exLdRegId;
                    end
                end
                LD_PEND: begin
                    if (memLdValid) begin
                        ldState <= exLdStart ? LD_PEND : LD_IDLE;
                        ldRegId <= exLdStart ? exLdRegId : UREG_ZZR;
                    end else if (exValid && idMatch(exRegId, ldRegId)) begin
                        ldState <= LD_STALE;
                    end
                end
                LD_STALE: begin
                    if (memLdValid) begin
                        ldState <= exLdStart ? LD_PEND : LD_IDLE;
                        ldRegId <= exLdStart ? exLdRegId : UREG_ZZR;
                    end
                end
                default: begin
                    ldState <= LD_IDLE;
                    ldRegId <= UREG_ZZR;
                end
            endcase
        end
    end

    assign wbLdPend = (ldState != LD_IDLE);

    // Stall request toward ID/EX
    always_comb begin
        wbHold = fifoFull;
        if (ldState == LD_PEND) begin
            if (idMatch(idRegIdRs, ldRegId) || idMatch(idRegIdRt, ldRegId))
                wbHold = 1'b1;
            if (exValid && idMatch(exRegId, ldRegId))
                wbHold = 1'b1;
        end
        if (wbLdPend && exLdStart && !memLdValid)
            wbHold = 1'b1;
    end

    // Youngest match wins: queue tail, queue head, output stage
    function automatic logic [DATA_W:0] fwdPick(
        input logic [UREG_W-1:0] id
    );
        fwdPick = '0;
        if (idMatch(id, regIdRo))
            fwdPick = {1'b1, regValRo};
        if (!fifoEmpty && idMatch(id, headId))
            fwdPick = {1'b1, headVal};
        if (fifoFull && idMatch(id, secId))
            fwdPick = {1'b1, secVal};
    endfunction

    assign {fwdHitRs, fwdValRs} = fwdPick(idRegIdRs);
    assign {fwdHitRt, fwdValRt} = fwdPick(idRegIdRt);

endmodule

// File: tb/tb_reg_wb_stage.sv
// Directed bench for reg_wb_stage: write port timing, load collisions,
// overflow, interlock/WAW, forwarding priority and reset mid-load.
module tb_reg_wb_stage;

    localparam logic [6:0] ZZR = 7'h7F;
    localparam logic [6:0] SR = 7'h40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exValid;
    logic [6:0]  exRegId;
    logic [31:0] exRegVal;
    logic        exLdStart;
    logic [6:0]  exLdRegId;
    logic        memLdValid;
    logic [31:0] memLdData;
    logic [6:0]  idRegIdRs;
    logic [6:0]  idRegIdRt;
    logic        fwdHitRs;
    logic [31:0] fwdValRs;
    logic        fwdHitRt;
    logic [31:0] fwdValRt;
    logic [6:0]  regIdRo;
    logic [31:0] regValRo;
    logic        wbHold;
    logic        wbLdPend;
    logic        wbOvf;

    int nCmp = 0;
    int nBad = 0;
    logic [31:0] lastR8 = 32'h0;

    reg_wb_stage dut (
        .clock      (clock),
        .reset      (reset),
        .exValid    (exValid),
        .exRegId    (exRegId),
        .exRegVal   (exRegVal),
        .exLdStart  (exLdStart),
        .exLdRegId  (exLdRegId),
        .memLdValid (memLdValid),
        .memLdData  (memLdData),
        .idRegIdRs  (idRegIdRs),
        .idRegIdRt  (idRegIdRt),
        .fwdHitRs   (fwdHitRs),
        .fwdValRs   (fwdValRs),
        .fwdHitRt   (fwdHitRt),
        .fwdValRt   (fwdValRt),
        .regIdRo    (regIdRo),
        .regValRo   (regValRo),
        .wbHold     (wbHold),
        .wbLdPend   (wbLdPend),
        .wbOvf      (wbOvf)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && regIdRo == 7'd8)
            lastR8 = regValRo;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        exValid = 0; exRegId = ZZR; exRegVal = 0;
        exLdStart = 0; exLdRegId = ZZR;
        memLdValid = 0; memLdData = 0;
        idRegIdRs = ZZR; idRegIdRt = ZZR;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ex(input logic [6:0] id, input logic [31:0] v);
        exValid = 1; exRegId = id; exRegVal = v;
    endtask

    task automatic ld(input logic [6:0] id);
        exLdStart = 1; exLdRegId = id;
    endtask

    task automatic ret(input logic [31:0] d);
        memLdValid = 1; memLdData = d;
    endtask

    task automatic wport(input string tag, input logic [6:0] id,
                         input logic [31:0] v);
        chk({tag, ".id"}, 32'(regIdRo), 32'(id));
        chk({tag, ".val"}, regValRo, v);
    endtask

    initial begin
        idle();
        #12;
        chk("rst.id", 32'(regIdRo), 32'(ZZR));
        chk("rst.val", regValRo, 0);
        chk("rst.pend", 32'(wbLdPend), 0);
        chk("rst.ovf", 32'(wbOvf), 0);
        chk("rst.hold", 32'(wbHold), 0);
        reset = 1;
        tick();

        // single write
        ex(7'd3, 32'h1234);
        tick();
        wport("single.c1", 7'd3, 32'h1234);
        idle();
        idRegIdRs = 7'd3;
        #1;
        chk("single.fwdHit", 32'(fwdHitRs), 1);
        chk("single.fwdVal", fwdValRs, 32'h1234);
        tick();
        wport("single.c2", ZZR, 0);
        chk("single.noHit", 32'(fwdHitRs), 0);
        chk("single.noVal", fwdValRs, 0);
        idle();

        // collision of load return with an ALU result
        ld(7'd5);
        tick();
        chk("coll.pend", 32'(wbLdPend), 1);
        idle();
        idRegIdRs = 7'd5;
        #1;
        chk("coll.holdRs", 32'(wbHold), 1);
        chk("coll.noFwd", 32'(fwdHitRs), 0);
        tick();
        idle();
        tick();
        ret(32'hAAAA);
        ex(7'd2, 32'd7);
        tick();
        wport("coll.c4", 7'd5, 32'hAAAA);
        idle();
        tick();
        wport("coll.c5", 7'd2, 32'd7);
        chk("coll.idle", 32'(wbLdPend), 0);
        tick();
        wport("coll.c6", ZZR, 0);

        // overflow: three back-to-back load returns with ALU results
        ld(7'd9);
        tick();
        ret(32'hD0); ld(7'd10); ex(7'd1, 32'd1);
        tick();
        wport("ovf.c0", 7'd9, 32'hD0);
        idle();
        ret(32'hD1); ld(7'd11); ex(7'd2, 32'd2);
        #1;
        chk("ovf.noHold", 32'(wbHold), 0);
        tick();
        wport("ovf.c1", 7'd10, 32'hD1);
        idle();
        ret(32'hD2); ex(7'd4, 32'd4);
        idRegIdRs = 7'd2; idRegIdRt = 7'd1;
        #1;
        chk("ovf.hold", 32'(wbHold), 1);
        chk("ovf.fwdTail", fwdValRs, 2);
        chk("ovf.fwdHead", fwdValRt, 1);
        chk("ovf.hitHead", 32'(fwdHitRt), 1);
        tick();
        wport("ovf.c2", 7'd11, 32'hD2);
        chk("ovf.flag", 32'(wbOvf), 1);
        idle();
        tick();
        wport("ovf.q0", 7'd1, 32'd1);
        tick();
        wport("ovf.q1", 7'd2, 32'd2);
        tick();
        wport("ovf.drop", ZZR, 0);
        chk("ovf.sticky", 32'(wbOvf), 1);

        // interlock and WAW protection
        ld(7'd8);
        tick();
        idle();
        idRegIdRs = 7'd8;
        #1;
        chk("waw.hold", 32'(wbHold), 1);
        chk("waw.noFwd", 32'(fwdHitRs), 0);
        idle();
        ex(7'd8, 32'd9);
        #1;
        chk("waw.holdEx", 32'(wbHold), 1);
        tick();
        wport("waw.alu", 7'd8, 32'd9);
        chk("waw.stale", 32'(wbLdPend), 1);
        idle();
        ret(32'hBEEF);
        #1;
        chk("waw.staleNoHold", 32'(wbHold), 0);
        tick();
        wport("waw.noWrite", ZZR, 0);
        chk("waw.done", 32'(wbLdPend), 0);
        idle();
        tick();
        chk("waw.lastR8", lastR8, 9);

        // forwarding priority across queue and output stage
        ld(7'd12);
        tick();
        ret(32'hC12); ld(7'd13); ex(7'd1, 32'd5);
        tick();
        idle();
        ret(32'hC13); ex(7'd1, 32'd6);
        tick();
        idle();
        idRegIdRs = 7'd1; idRegIdRt = 7'd13;
        #1;
        chk("fwd.tailHit", 32'(fwdHitRs), 1);
        chk("fwd.tailVal", fwdValRs, 6);
        chk("fwd.outVal", fwdValRt, 32'hC13);
        tick();
        wport("fwd.head", 7'd1, 32'd5);
        chk("fwd.qOverOut", fwdValRs, 6);
        tick();
        wport("fwd.tail", 7'd1, 32'd6);
        chk("fwd.out", fwdValRs, 6);
        tick();
        chk("fwd.gone", 32'(fwdHitRs), 0);

        // control UREG id and the no-register id
        idle();
        ex(SR, 32'h55);
        tick();
        idle();
        idRegIdRs = SR;
        #1;
        chk("sr.fwd", fwdValRs, 32'h55);
        ex(ZZR, 32'h77);
        idRegIdRt = ZZR;
        tick();
        wport("zzr.noWrite", ZZR, 0);
        chk("zzr.noHit", 32'(fwdHitRt), 0);

        // reset while a load is pending
        idle();
        ld(7'd6);
        tick();
        chk("rl.pend", 32'(wbLdPend), 1);
        idle();
        #2;
        reset = 0;
        #1;
        chk("rl.pendClr", 32'(wbLdPend), 0);
        chk("rl.ovfClr", 32'(wbOvf), 0);
        #10;
        reset = 1;
        tick();
        ret(32'hDEAD);
        tick();
        wport("rl.ignored", ZZR, 0);
        chk("rl.idle", 32'(wbLdPend), 0);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
